// File: rtl/adc_pkg.sv
// adc_pkg: shared types and widths for the ADC serial link.
// Exports the receiver FSM state type and the conversion word width.
package adc_pkg;
  localparam int ADC_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_END
  } adc_rx_state_t;
endpackage

// File: rtl/adc_serial_rx_if.sv
// adc_serial_rx_if: serial pins plus the received-word outputs.
// master drives sclk/cs_n/sdata; slave (receiver) drives data/valid/frame_err/busy.
interface adc_serial_rx_if
  import adc_pkg::*;
#(
  parameter int DW = ADC_DATA_WIDTH
);
  logic          sclk;
  logic          cs_n;
  logic          sdata;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  modport master (
    output sclk, cs_n, sdata,
    input  data, valid, frame_err, busy
  );

  modport slave (
    input  sclk, cs_n, sdata,
    output data, valid, frame_err, busy
  );
endinterface

// File: rtl/sync_edge.sv
// sync_edge: STAGES-flop synchroniser with registered rise/fall strobes.
// Ports: clk, rst_n, i_d (async in), o_q (sync level), o_rise, o_fall.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;

  assign w_s = r_sync[STAGES-1];

  // Edge strobes are registered, so o_q is taken from the history
  // flop to stay aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= w_s;
      r_rise <= w_s & ~r_hist;
      r_fall <= ~w_s & r_hist;
    end
  end

  assign o_q    = r_hist;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: oversampled MSB-first deserialiser with framing check.
// Ports: clk, rst_n, bus (slave: sclk/cs_n/sdata in; data/valid/frame_err/busy out).
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  adc_serial_rx_if.slave  bus
);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_sd, w_sd_rise, w_sd_fall;
  logic w_unused;
  logic w_last;
  logic [DATA_WIDTH-1:0] w_shift;

  adc_rx_state_t         r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ovr;
  logic                  r_valid;
  logic                  r_ferr;
  logic [SW-1:0]         r_settle;
  logic                  r_armed;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .i_d(bus.cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sd (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sdata),
    .o_q(w_sd), .o_rise(w_sd_rise), .o_fall(w_sd_fall)
  );

  assign w_unused = ^{w_sclk_q, w_sclk_fall, w_sd_rise, w_sd_fall};
  assign w_shift  = {r_shreg[DATA_WIDTH-2:0], w_sd};
  assign w_last   = w_sclk_rise && (r_cnt == CNT_LAST);

  // A frame caught mid-flight by reset must not be picked up: cs_fall
  // is honoured only after cs_n has been seen high once the
  // synchroniser has flushed its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_ovr    <= 1'b0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_settle != SW'(SETTLE)) begin
        r_settle <= r_settle + SW'(1);
      end else if (w_cs_q) begin
        r_armed <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall && r_armed) begin
            r_cnt   <= '0;
            r_shreg <= '0;
            r_ovr   <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_sclk_rise && r_cnt != CNT_MAX) begin
            r_shreg <= w_shift;
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
          end
          if (w_cs_rise) begin
            // the bit arriving with cs_rise counts toward the word
            if (w_last) begin
              r_data  <= w_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
            r_state <= IDLE;
          end else if (w_last) begin
            r_state <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (w_sclk_rise) r_ovr <= 1'b1;
          if (w_cs_rise) begin
            if (r_ovr || w_sclk_rise) begin
              r_ferr  <= 1'b1;
            end else begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_adc_serial_rx.sv
// tb_adc_serial_rx: randomized frame-level bench for adc_serial_rx.
// Drives the serial pins, models outcomes per frame, checks events.
module tb_adc_serial_rx;
  import adc_pkg::*;

  localparam int DW = ADC_DATA_WIDTH;
  localparam int SS = 2;

  typedef struct {
    bit          ok;
    logic [DW-1:0] d;
    int          lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pin_cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [DW-1:0] exp_data = '0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  adc_serial_rx_if #(.DW(DW)) bus ();

  adc_serial_rx #(
    .DATA_WIDTH(DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ev_t e;
    if (bus.valid) begin
      e.ok = 1'b1; e.d = bus.data; e.lat = cyc - pin_cyc;
      obs_q.push_back(e);
    end
    if (bus.frame_err) begin
      e.ok = 1'b0; e.d = bus.data; e.lat = cyc - pin_cyc;
      obs_q.push_back(e);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cw(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a frame is good exactly when DW sclk rises occur
  // while cs_n is low (a rise coinciding with cs_n rise counts).
  task automatic model(input logic [DW-1:0] w, input int nb);
    ev_t e;
    e.ok  = (nb == DW);
    e.d   = w;
    e.lat = SS + 2;
    exp_q.push_back(e);
    if (e.ok) exp_data = w;
  endtask

  task automatic drive_frame(input logic [DW-1:0] w,
                             input logic [3:0] ext,
                             input int nb,
                             input bit coinc,
                             input int hp,
                             input bit fin);
    logic [DW+3:0] v;
    v = {w, ext};
    bus.cs_n = 1'b0;
    bus.sclk = 1'b0;
    cw(hp);
    for (int i = 0; i < nb; i++) begin
      bus.sdata = v[DW+3-i];
      cw(hp);
      if (coinc && fin && i == nb - 1) begin
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        pin_cyc  = cyc;
        cw(hp);
        bus.sclk = 1'b0;
      end else begin
        bus.sclk = 1'b1;
        cw(hp);
        bus.sclk = 1'b0;
      end
    end
    if (fin && !coinc) begin
      cw(hp);
      bus.cs_n = 1'b1;
      pin_cyc  = cyc;
    end
    if (fin) model(w, nb);
  endtask

  task automatic verify(input string tag);
    int n;
    cw(12);
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, 32'(obs_q[i].ok), 32'(exp_q[i].ok));
      if (exp_q[i].ok) begin
        chk({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
        chk({tag, "_lat"}, obs_q[i].lat, exp_q[i].lat);
      end
    end
    chk({tag, "_hold"}, 32'(bus.data), 32'(exp_data));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int nb;
    logic [DW-1:0] w;
    bus.sclk  = 1'b0;
    bus.cs_n  = 1'b1;
    bus.sdata = 1'b0;
    cw(3);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    cw(10);

    drive_frame(12'hA5C, 4'h0, 12, 1'b0, 5, 1'b1);
    verify("good_a5c");

    drive_frame(12'h5A3, 4'h0, 7, 1'b0, 5, 1'b1);
    verify("short7");

    drive_frame(12'hFFF, 4'h8, 13, 1'b0, 5, 1'b1);
    verify("overrun");

    drive_frame(12'h001, 4'h0, 12, 1'b0, 5, 1'b1);
    cw(2);
    drive_frame(12'h800, 4'h0, 12, 1'b0, 5, 1'b1);
    verify("b2b");

    w = 12'($urandom);
    drive_frame(w, 4'h0, 6, 1'b0, 5, 1'b0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(bus.data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_flags", 32'({bus.valid, bus.frame_err}), 32'd0);
    exp_data = '0;
    cw(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.sdata = w[5-i];
      cw(5);
      bus.sclk = 1'b1;
      cw(5);
      bus.sclk = 1'b0;
    end
    cw(5);
    bus.cs_n = 1'b1;
    pin_cyc  = cyc;
    verify("mid_rst");
    drive_frame(12'h3C3, 4'h0, 12, 1'b0, 5, 1'b1);
    verify("post_rst");

    drive_frame(12'h69B, 4'h0, 12, 1'b1, 5, 1'b1);
    verify("coinc");

    for (int k = 0; k < 24; k++) begin
      w  = 12'($urandom);
      nb = ($urandom_range(0, 2) != 0) ? DW : int'($urandom_range(1, 16));
      drive_frame(w, 4'($urandom), nb, 1'($urandom),
                  int'($urandom_range(2, 6)), 1'b1);
      cw(int'($urandom_range(2, 4)));
      verify("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
